keypad_entry: RTL

Consumes the registered key-code stream produced by the keypad column scanner and turns it into clean, single key events, then assembles them into a two-operand calculator entry (operand A, operator, operand B, enter). It sits directly downstream of the scanner and upstream of the arithmetic/display logic. It filters the intermittent, column-gated presence of a held key into exactly one event per physical press.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_entry_if.sv | 27 ++
 rtl/key_event_filter.sv | 131 +++++++++++++
 rtl/keypad_entry.sv | 135 +++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key-code constants and state encodings for the keypad scanner,
// the key event filter and the calculator entry logic.
package keypad_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] KEY_OP_BASE = 4'hA;
    localparam logic [3:0] KEY_STAR    = 4'hE;
    localparam logic [3:0] KEY_HASH    = 4'hF;

    typedef enum logic [1:0] {
        ENTER_A    = 2'd0,
        ENTER_B    = 2'd1,
        ENTRY_DONE = 2'd2
    } entry_state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        F_IDLE     = 2'd0,
        F_COUNTING = 2'd1,
        F_HELD     = 2'd2
    } filt_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'h9;
    endfunction

    function automatic logic is_op(input logic [3:0] code);
        return (code >= KEY_OP_BASE) && (code < KEY_STAR);
    endfunction

    function automatic op_t code_to_op(input logic [3:0] code);
        logic [3:0] diff;
        diff = code - KEY_OP_BASE;
        return op_t'(diff[1:0]);
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Bundle between the keypad scanner (master) and the entry block (slave):
// raw scanner key stream in, accepted events and calculator entry out.
interface keypad_entry_if #(
    parameter int MAX_DIGITS = 3
);
    logic                      key_hit;
    logic [3:0]                key_code;
    logic                      key_event;
    logic [3:0]                key_event_code;
    logic [4*MAX_DIGITS-1:0]   operand_a;
    logic [4*MAX_DIGITS-1:0]   operand_b;
    logic [1:0]                op;
    logic [1:0]                entry_state;
    logic                      done;

    modport master (
        output key_hit, key_code,
        input  key_event, key_event_code, operand_a, operand_b, op,
               entry_state, done
    );

    modport slave (
        input  key_hit, key_code,
        output key_event, key_event_code, operand_a, operand_b, op,
               entry_state, done
    );
endinterface

// File: rtl/key_event_filter.sv
// Turns the column-gated, intermittent key_hit stream into exactly one
// accepted event per physical press. 'accept'/'accept_code' are the
// combinational decision for this cycle so the entry FSM can update on the
// same edge that registers key_event.
module key_event_filter
    import keypad_pkg::*;
#(
    parameter int PRESS_HITS     = 4096,
    parameter int RELEASE_CYCLES = 270_000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       key_hit,
    input  logic [3:0] key_code,
    output logic       accept,
    output logic [3:0] accept_code,
    output logic       key_event,
    output logic [3:0] key_event_code
);

    localparam int HIT_W = $clog2(PRESS_HITS + 1);
    localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
    localparam logic [HIT_W-1:0] HIT_MAX = HIT_W'(PRESS_HITS);
    localparam logic [REL_W-1:0] REL_MAX = REL_W'(RELEASE_CYCLES);
    localparam logic [HIT_W-1:0] HIT_ONE = HIT_W'(1);

    filt_state_t       state, state_nxt;
    logic [3:0]        code_q, code_nxt;
    logic [HIT_W-1:0]  hit_cnt, hit_nxt, hit_inc;
    logic [REL_W-1:0]  rel_cnt, rel_nxt, rel_inc;

    // Both counters saturate instead of wrapping.
    assign hit_inc = (hit_cnt == HIT_MAX) ? hit_cnt : hit_cnt + 1'b1;
    assign rel_inc = (rel_cnt == REL_MAX) ? rel_cnt : rel_cnt + 1'b1;
    assign accept_code = code_nxt;

    // Filter state, latched code and counters.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= F_IDLE;
            code_q  <= '0;
            hit_cnt <= '0;
            rel_cnt <= '0;
        end else begin
            state   <= state_nxt;
            code_q  <= code_nxt;
            hit_cnt <= hit_nxt;
            rel_cnt <= rel_nxt;
        end
    end

    // Press qualification and release detection.
    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        hit_nxt   = hit_cnt;
        rel_nxt   = rel_cnt;
        accept    = 1'b0;
        case (state)
            F_IDLE: begin
                if (key_hit) begin
                    code_nxt  = key_code;
                    hit_nxt   = HIT_ONE;
                    rel_nxt   = '0;
                    state_nxt = F_COUNTING;
                    if (HIT_ONE >= HIT_MAX) begin
                        accept    = 1'b1;
                        state_nxt = F_HELD;
                    end
                end
            end
            F_COUNTING: begin
                if (key_hit) begin
                    rel_nxt = '0;
                    if (key_code != code_q) begin
                        // A different key restarts qualification from scratch.
                        code_nxt = key_code;
                        hit_nxt  = HIT_ONE;
                        if (HIT_ONE >= HIT_MAX) begin
                            accept    = 1'b1;
                            state_nxt = F_HELD;
                        end
                    end else begin
                        hit_nxt = hit_inc;
                        if (hit_inc == HIT_MAX) begin
                            accept    = 1'b1;
                            state_nxt = F_HELD;
                        end
                    end
                end else begin
                    rel_nxt = rel_inc;
                    if (rel_inc == REL_MAX) begin
                        state_nxt = F_IDLE;
                        hit_nxt   = '0;
                        rel_nxt   = '0;
                    end
                end
            end
            F_HELD: begin
                // Any hit keeps the key held, even on the would-be timeout cycle.
                if (key_hit) begin
                    rel_nxt = '0;
                end else begin
                    rel_nxt = rel_inc;
                    if (rel_inc == REL_MAX) begin
                        state_nxt = F_IDLE;
                        hit_nxt   = '0;
                        rel_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = F_IDLE;
                hit_nxt   = '0;
                rel_nxt   = '0;
            end
        endcase
    end

    // Registered event pulse and sticky code of the last accepted press.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            key_event      <= 1'b0;
            key_event_code <= '0;
        end else begin
            key_event <= accept;
            if (accept) key_event_code <= code_nxt;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Calculator entry: filters the scanner stream into key events and
// assembles operand A, operator, operand B and '#' into a finished entry.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int CLK_HZ         = 27_000_000,
    parameter int PRESS_HITS     = 4096,
    parameter int RELEASE_CYCLES = CLK_HZ / 100,
    parameter int MAX_DIGITS     = 3
) (
    input  logic          clk,
    input  logic          n_reset,
    keypad_entry_if.slave bus
);

    localparam int OPND_W = DIGIT_W * MAX_DIGITS;
    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    logic              accept;
    logic [3:0]        accept_code;
    logic              key_event;
    logic [3:0]        key_event_code;

    entry_state_t      st, st_n;
    logic [OPND_W-1:0] opa, opa_n, opb, opb_n;
    op_t               op_q, op_n;
    logic [CNT_W-1:0]  cnt_a, cnt_a_n, cnt_b, cnt_b_n;
    logic              done_q, done_n;

    key_event_filter #(
        .PRESS_HITS     (PRESS_HITS),
        .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_filter (
        .clk            (clk),
        .n_reset        (n_reset),
        .key_hit        (bus.key_hit),
        .key_code       (bus.key_code),
        .accept         (accept),
        .accept_code    (accept_code),
        .key_event      (key_event),
        .key_event_code (key_event_code)
    );

    // Entry registers; they move on the same edge that registers key_event.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            st     <= ENTER_A;
            opa    <= '0;
            opb    <= '0;
            op_q   <= OP_ADD;
            cnt_a  <= '0;
            cnt_b  <= '0;
            done_q <= 1'b0;
        end else begin
            st     <= st_n;
            opa    <= opa_n;
            opb    <= opb_n;
            op_q   <= op_n;
            cnt_a  <= cnt_a_n;
            cnt_b  <= cnt_b_n;
            done_q <= done_n;
        end
    end

    // Entry FSM: only accepted events change anything; ignored keys hold state.
    always_comb begin
        st_n    = st;
        opa_n   = opa;
        opb_n   = opb;
        op_n    = op_q;
        cnt_a_n = cnt_a;
        cnt_b_n = cnt_b;
        done_n  = 1'b0;
        if (accept) begin
            if (accept_code == KEY_STAR) begin
                st_n    = ENTER_A;
                opa_n   = '0;
                opb_n   = '0;
                op_n    = OP_ADD;
                cnt_a_n = '0;
                cnt_b_n = '0;
            end else begin
                case (st)
                    ENTER_A: begin
                        if (is_digit(accept_code)) begin
                            if (cnt_a < CNT_MAX) begin
                                opa_n   = (opa << DIGIT_W) | OPND_W'(accept_code);
                                cnt_a_n = cnt_a + 1'b1;
                            end
                        end else if (is_op(accept_code) && cnt_a != '0) begin
                            op_n = code_to_op(accept_code);
                            st_n = ENTER_B;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit(accept_code)) begin
                            if (cnt_b < CNT_MAX) begin
                                opb_n   = (opb << DIGIT_W) | OPND_W'(accept_code);
                                cnt_b_n = cnt_b + 1'b1;
                            end
                        end else if (is_op(accept_code)) begin
                            // Operator can still be changed until B has a digit.
                            if (cnt_b == '0) op_n = code_to_op(accept_code);
                        end else if (accept_code == KEY_HASH && cnt_b != '0) begin
                            st_n   = ENTRY_DONE;
                            done_n = 1'b1;
                        end
                    end
                    ENTRY_DONE: begin
                        // A digit after a finished entry starts a new operand A.
                        if (is_digit(accept_code)) begin
                            opa_n   = OPND_W'(accept_code);
                            cnt_a_n = CNT_W'(1);
                            opb_n   = '0;
                            cnt_b_n = '0;
                            op_n    = OP_ADD;
                            st_n    = ENTER_A;
                        end
                    end
                    default: st_n = ENTER_A;
                endcase
            end
        end
    end

    assign bus.key_event      = key_event;
    assign bus.key_event_code = key_event_code;
    assign bus.operand_a      = opa;
    assign bus.operand_b      = opb;
    assign bus.op             = op_q;
    assign bus.entry_state    = st;
    assign bus.done           = done_q;

endmodule
